// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// video_timing_pkg : vertical state encoding and default raster geometry
// Revision 1.0
// ============================================================================
package video_timing_pkg;

  typedef enum logic [1:0] {
    VS_ACTIVE = 2'd0,
    VS_FRONT  = 2'd1,
    VS_SYNC   = 2'd2,
    VS_BACK   = 2'd3
  } vstate_t;

  localparam int   DEF_H_WIDTH      = 8;
  localparam int   DEF_V_WIDTH      = 10;
  localparam int   DEF_H_ACTIVE     = 200;
  localparam int   DEF_H_SYNC_START = 210;
  localparam int   DEF_H_SYNC_END   = 230;
  localparam int   DEF_V_ACTIVE     = 480;
  localparam int   DEF_V_FRONT      = 10;
  localparam int   DEF_V_SYNC       = 2;
  localparam int   DEF_V_BACK       = 33;
  localparam logic DEF_SYNC_POL     = 1'b0;

  // Drive level of a sync output given its polarity and whether it is asserted.
  function automatic logic sync_level(input logic pol, input logic on);
    return on ? pol : ~pol;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_rise_det.sv
`default_nettype none
// ============================================================================
// pulse_rise_det : registered rising-edge detector (rise = sig & ~sig_q)
// Revision 1.0
// ============================================================================
module pulse_rise_det (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : line counter, vertical FSM, registered HSYNC/VSYNC/DE and
// frame-start strobe. Optional upstream checker: define VIDEO_TIMING_CHECK_EN.
// Revision 1.0
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_WIDTH      = DEF_H_WIDTH,
  parameter int   V_WIDTH      = DEF_V_WIDTH,
  parameter int   H_ACTIVE     = DEF_H_ACTIVE,
  parameter int   H_SYNC_START = DEF_H_SYNC_START,
  parameter int   H_SYNC_END   = DEF_H_SYNC_END,
  parameter int   V_ACTIVE     = DEF_V_ACTIVE,
  parameter int   V_FRONT      = DEF_V_FRONT,
  parameter int   V_SYNC       = DEF_V_SYNC,
  parameter int   V_BACK       = DEF_V_BACK,
  parameter logic SYNC_POL     = DEF_SYNC_POL
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [H_WIDTH-1:0] h_count,
  input  logic               line_tc,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [V_WIDTH-1:0] line,
  output logic               frame_start,
  output logic               timing_err
);

  localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_WIDTH-1:0] c_h_active     = H_WIDTH'(H_ACTIVE);
  localparam logic [H_WIDTH-1:0] c_h_sync_start = H_WIDTH'(H_SYNC_START);
  localparam logic [H_WIDTH-1:0] c_h_sync_end   = H_WIDTH'(H_SYNC_END);
  localparam logic [V_WIDTH-1:0] c_v_last       = V_WIDTH'(c_v_total - 1);
  localparam logic [V_WIDTH-1:0] c_front_start  = V_WIDTH'(V_ACTIVE);
  localparam logic [V_WIDTH-1:0] c_sync_start   = V_WIDTH'(V_ACTIVE + V_FRONT);
  localparam logic [V_WIDTH-1:0] c_back_start   = V_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

  logic               tc_rise;
  logic               advance;
  logic               wrap;
  logic               h_in_active;
  logic               h_in_sync;

  vstate_t            state_q, state_d;
  logic [V_WIDTH-1:0] line_q, line_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic               fs_q, fs_d;

  pulse_rise_det u_tc_rise (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (line_tc),
    .rise_o (tc_rise)
  );

  assign advance     = enable & tc_rise;
  assign wrap        = advance & (line_q == c_v_last);
  assign h_in_active = (h_count < c_h_active);
  assign h_in_sync   = (h_count >= c_h_sync_start) & (h_count < c_h_sync_end);

  always_comb begin
    line_d = line_q;
    if (wrap) begin
      line_d = '0;
    end else if (advance) begin
      line_d = line_q + V_WIDTH'(1);
    end
  end

  // Outputs are computed from the next state so the first pixel of a new line
  // is already gated by that line's vertical region.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        VS_ACTIVE: if (line_d == c_front_start) state_d = VS_FRONT;
        VS_FRONT:  if (line_d == c_sync_start)  state_d = VS_SYNC;
        VS_SYNC:   if (line_d == c_back_start)  state_d = VS_BACK;
        VS_BACK:   if (line_d == '0)            state_d = VS_ACTIVE;
        default:                                state_d = VS_ACTIVE;
      endcase
    end

    hsync_d = sync_level(SYNC_POL, enable & h_in_sync);
    vsync_d = sync_level(SYNC_POL, enable & (state_d == VS_SYNC));
    de_d    = enable & h_in_active & (state_d == VS_ACTIVE);
    fs_d    = wrap;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= VS_ACTIVE;
      line_q  <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line        = line_q;
  assign frame_start = fs_q;

`ifdef VIDEO_TIMING_CHECK_EN
  // miss_q counts H_SYNC_END crossings since the last line_tc edge; a third
  // crossing means two whole lines went by without a terminal count.
  logic [1:0] miss_q, miss_d;
  logic       err_q, err_d;

  always_comb begin
    miss_d = miss_q;
    err_d  = err_q;
    if (tc_rise) begin
      miss_d = 2'd0;
      if (h_count != '0) err_d = 1'b1;
    end else if (h_count == c_h_sync_end) begin
      if (miss_q == 2'd2) begin
        err_d = 1'b1;
      end else begin
        miss_d = miss_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      miss_q <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      miss_q <= miss_d;
      err_q  <= err_d;
    end
  end

  assign timing_err = err_q;
`else
  assign timing_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_video_timing_gen : scoreboard bench for video_timing_gen (default geometry)
// Revision 1.0
// ============================================================================
module tb_video_timing_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] h_count;
  logic       line_tc;
  logic       hsync, vsync, de, frame_start, timing_err;
  logic [9:0] line;

  video_timing_gen dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .h_count     (h_count),
    .line_tc     (line_tc),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .line        (line),
    .frame_start (frame_start),
    .timing_err  (timing_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0] line;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   m_line = 0;
  bit   m_tc_q = 1'b0;
  bit   m_err  = 1'b0;
  int   m_miss = 0;

  int   n_de, n_hs_low, n_vs_low, n_fs;
  int   fast_h [9] = '{0, 1, 199, 200, 209, 210, 229, 230, 250};

`ifdef VIDEO_TIMING_CHECK_EN
  localparam logic EXP_ERR_AFTER_BAD_TC = 1'b1;
`else
  localparam logic EXP_ERR_AFTER_BAD_TC = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the block, one clock edge ahead of the outputs.
  task automatic model_push(input bit en, input bit rst, input int h, input bit tc);
    exp_t e;
    bit   rise;
    if (rst) begin
      m_line = 0; m_tc_q = 1'b0; m_err = 1'b0; m_miss = 0;
      e.line = '0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0; e.err = 1'b0;
    end else begin
      rise   = tc && !m_tc_q;
      m_tc_q = tc;
      e.fs   = 1'b0;
      if (en && rise) begin
        if (m_line == 524) begin
          m_line = 0;
          e.fs   = 1'b1;
        end else begin
          m_line++;
        end
      end
      e.line = 10'(m_line);
      e.hs   = !(en && h >= 210 && h < 230);
      e.vs   = !(en && m_line >= 490 && m_line <= 491);
      e.de   = en && h < 200 && m_line < 480;
`ifdef VIDEO_TIMING_CHECK_EN
      if (rise) begin
        m_miss = 0;
        if (h != 0) m_err = 1'b1;
      end else if (h == 230) begin
        if (m_miss == 2) m_err = 1'b1;
        else m_miss++;
      end
`endif
      e.err = m_err;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input bit en, input bit rst, input int h, input bit tc);
    exp_t e;
    reset   = rst;
    enable  = en;
    h_count = 8'(h);
    line_tc = tc;
    model_push(en, rst, h, tc);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("line",        16'(line),        16'(e.line));
      chk("hsync",       16'(hsync),       16'(e.hs));
      chk("vsync",       16'(vsync),       16'(e.vs));
      chk("de",          16'(de),          16'(e.de));
      chk("frame_start", 16'(frame_start), 16'(e.fs));
      chk("timing_err",  16'(timing_err),  16'(e.err));
    end
    if (de === 1'b1)          n_de++;
    if (hsync === 1'b0)       n_hs_low++;
    if (vsync === 1'b0)       n_vs_low++;
    if (frame_start === 1'b1) n_fs++;
  endtask

  task automatic run_line(input bit fast, input int tc_len, input bit en);
    int n;
    int h;
    n = fast ? 9 : 251;
    for (int i = 0; i < n; i++) begin
      h = fast ? fast_h[i] : i;
      drive(en, 1'b0, h, i < tc_len);
    end
  endtask

  task automatic clear_counts();
    n_de = 0; n_hs_low = 0; n_vs_low = 0; n_fs = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    reset = 1'b1; enable = 1'b0; h_count = '0; line_tc = 1'b0;

    drive(1'b1, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b1, 0, 1'b0);

    // Full-length lines: DE/HSYNC windows and one advance per line.
    clear_counts();
    repeat (3) run_line(1'b0, 1, 1'b1);
    chk("full_de_cycles",   16'(n_de),     16'd600);
    chk("full_hsync_low",   16'(n_hs_low), 16'd60);
    chk("line_after_3",     16'(line),     16'd3);

    // One whole frame of shortened lines, through the wrap.
    clear_counts();
    repeat (525) run_line(1'b1, 1, 1'b1);
    chk("frame_fs_pulses",  16'(n_fs),     16'd1);
    chk("frame_vsync_low",  16'(n_vs_low), 16'd18);
    chk("frame_de_cycles",  16'(n_de),     16'd1440);
    chk("line_after_frame", 16'(line),     16'd3);

    // line_tc held high for three cycles advances once.
    run_line(1'b0, 3, 1'b1);
    chk("held_tc_line",     16'(line),     16'd4);

    guard = 0;
    while (m_line != 100 && guard < 600) begin
      run_line(1'b1, 1, 1'b1);
      guard++;
    end
    chk("reach_line_100",   16'(line),     16'd100);

    // Disabled for ~1000 cycles while the upstream counter keeps running.
    clear_counts();
    repeat (4) run_line(1'b0, 1, 1'b0);
    chk("hold_de_cycles",   16'(n_de),     16'd0);
    chk("hold_hsync_low",   16'(n_hs_low), 16'd0);
    chk("hold_line",        16'(line),     16'd100);
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b0, 1, 1'b1);
    for (int h = 2; h < 251; h++) drive(1'b1, 1'b0, h, 1'b0);
    chk("no_false_edge",    16'(line),     16'd100);
    run_line(1'b0, 1, 1'b1);
    chk("resume_line",      16'(line),     16'd101);

    // Reset in the middle of line 300.
    guard = 0;
    while (m_line != 299 && guard < 600) begin
      run_line(1'b1, 1, 1'b1);
      guard++;
    end
    for (int h = 0; h < 100; h++) drive(1'b1, 1'b0, h, h == 0);
    chk("at_line_300",      16'(line),     16'd300);
    drive(1'b1, 1'b1, 100, 1'b0);
    chk("reset_line",       16'(line),     16'd0);
    chk("reset_hsync",      16'(hsync),    16'd1);
    for (int h = 101; h < 251; h++) drive(1'b1, 1'b0, h, 1'b0);
    run_line(1'b0, 1, 1'b1);
    chk("after_reset_line", 16'(line),     16'd1);

    // Terminal count at h_count=37.
    for (int h = 0; h < 251; h++) drive(1'b1, 1'b0, h, (h == 0) || (h == 37));
    chk("bad_tc_err",       16'(timing_err), 16'(EXP_ERR_AFTER_BAD_TC));
    run_line(1'b0, 1, 1'b1);
    chk("bad_tc_sticky",    16'(timing_err), 16'(EXP_ERR_AFTER_BAD_TC));
    drive(1'b1, 1'b1, 0, 1'b0);
    chk("err_cleared",      16'(timing_err), 16'd0);

    chk("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
